// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet link monitor: FSM encoding, default
// qualification lengths and a saturating-increment helper.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_DOWN      = 2'd0,
    ST_QUAL_UP   = 2'd1,
    ST_UP        = 2'd2,
    ST_QUAL_DOWN = 2'd3
  } link_state_e;

  localparam int unsigned DEF_UP_CYCLES   = 1024;
  localparam int unsigned DEF_DOWN_CYCLES = 16;

  // Increment val, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; a clear that coincides
// with an increment leaves the counter at 1 so the event is not lost.
module sat_counter
  import eth_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc) begin
      count <= W'(sat_inc(32'(count), W));
    end
  end

endmodule

// File: rtl/eth_link_monitor.sv
// Debounces the CMAC PCS-alignment flag into a clean eth_up level with
// asymmetric hysteresis, and counts drops and glitches. Optional uptime
// counter is built when ETH_LINK_UPTIME_EN is defined.
module eth_link_monitor
  import eth_pkg::*;
#(
  parameter int unsigned UP_CYCLES   = DEF_UP_CYCLES,
  parameter int unsigned DOWN_CYCLES = DEF_DOWN_CYCLES,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_aligned,
  input  logic             clear_counts,
  output logic             eth_up,
  output logic             up_event,
  output logic             down_event,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] glitch_count,
`ifdef ETH_LINK_UPTIME_EN
  output logic [31:0]      uptime,
`endif
  output link_state_e      link_state
);

  localparam int unsigned MAX_CYC = (UP_CYCLES > DOWN_CYCLES) ? UP_CYCLES : DOWN_CYCLES;
  localparam int unsigned QW      = $clog2(MAX_CYC);
  localparam logic [QW-1:0] UP_LAST   = QW'(UP_CYCLES - 1);
  localparam logic [QW-1:0] DOWN_LAST = QW'(DOWN_CYCLES - 1);

  link_state_e   state_q, state_d;
  logic [QW-1:0] q_cnt, q_cnt_d;
  logic          aligned_q;
  logic          up_fire, down_fire, glitch_fire;

  assign link_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_DOWN;
      q_cnt      <= '0;
      aligned_q  <= 1'b0;
      eth_up     <= 1'b0;
      up_event   <= 1'b0;
      down_event <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_cnt      <= q_cnt_d;
      aligned_q  <= rx_aligned;
      eth_up     <= (state_d == ST_UP) || (state_d == ST_QUAL_DOWN);
      up_event   <= up_fire;
      down_event <= down_fire;
    end
  end

  // Qualifying states count consecutive cycles of the new level; any
  // contrary sample sends the FSM straight back to where it came from.
  always_comb begin
    state_d     = state_q;
    q_cnt_d     = q_cnt;
    up_fire     = 1'b0;
    down_fire   = 1'b0;
    glitch_fire = 1'b0;
    case (state_q)
      ST_DOWN: begin
        if (aligned_q) begin
          state_d = ST_QUAL_UP;
          q_cnt_d = QW'(1);
        end
      end
      ST_QUAL_UP: begin
        if (!aligned_q) begin
          state_d = ST_DOWN;
          q_cnt_d = '0;
        end else if (q_cnt == UP_LAST) begin
          state_d = ST_UP;
          q_cnt_d = '0;
          up_fire = 1'b1;
        end else begin
          q_cnt_d = q_cnt + QW'(1);
        end
      end
      ST_UP: begin
        if (!aligned_q) begin
          state_d = ST_QUAL_DOWN;
          q_cnt_d = QW'(1);
        end
      end
      ST_QUAL_DOWN: begin
        if (aligned_q) begin
          state_d     = ST_UP;
          q_cnt_d     = '0;
          glitch_fire = 1'b1;
        end else if (q_cnt == DOWN_LAST) begin
          state_d   = ST_DOWN;
          q_cnt_d   = '0;
          down_fire = 1'b1;
        end else begin
          q_cnt_d = q_cnt + QW'(1);
        end
      end
      default: begin
        state_d = ST_DOWN;
        q_cnt_d = '0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (down_fire),
    .clr   (clear_counts),
    .count (drop_count)
  );

  sat_counter #(.W(CNT_W)) u_glitch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (glitch_fire),
    .clr   (clear_counts),
    .count (glitch_count)
  );

`ifdef ETH_LINK_UPTIME_EN
  // Cleared on the edge that enters UP (eth_up is still 0 then), so the
  // count restarts for each session and holds after the link drops.
  sat_counter #(.W(32)) u_uptime_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (eth_up),
    .clr   (up_fire),
    .count (uptime)
  );
`endif

endmodule

// File: doc/eth_link_monitor.md
Name: eth_link_monitor

Overview:
- Per-port link qualifier upstream of the Ethernet status/LED register block.
- Takes the raw CMAC PCS-alignment flag (rx_aligned) in the CMAC RX clock domain and debounces it with asymmetric hysteresis to produce a clean eth_up level. That level feeds the status block's eth0_up/eth1_up inputs.
- Counts link drops and short alignment glitches for AXI readout; emits single-cycle up/down event pulses.

Parameters:
- UP_CYCLES, 1024: consecutive aligned cycles required before declaring link up. Must be >= 2.
- DOWN_CYCLES, 16: consecutive unaligned cycles required before declaring link down. Must be >= 2.
- CNT_W, 16: width of drop_count and glitch_count.

Ports:
- clk  in  1  CMAC RX user clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- rx_aligned  in  1  raw PCS-alignment status, synchronous to clk.
- clear_counts  in  1  one-cycle pulse; zeroes drop_count and glitch_count.
- eth_up  out  1  qualified link-up level (registered).
- up_event  out  1  one-cycle pulse on entry to UP.
- down_event  out  1  one-cycle pulse on entry to DOWN from QUAL_DOWN.
- drop_count  out  CNT_W  saturating count of UP->DOWN transitions.
- glitch_count  out  CNT_W  saturating count of QUAL_DOWN->UP recoveries.

Behaviour:
- Input register: aligned_q <= rx_aligned every edge. All FSM decisions use aligned_q only.
- Qualification counter q_cnt: width clog2(max(UP_CYCLES,DOWN_CYCLES)).
- States and transitions:
  - DOWN: if aligned_q=1 -> QUAL_UP, q_cnt<=1.
  - QUAL_UP: if aligned_q=0 -> DOWN (no count). Else if q_cnt==UP_CYCLES-1 -> UP with up_event=1. Else q_cnt++.
  - UP: if aligned_q=0 -> QUAL_DOWN, q_cnt<=1.
  - QUAL_DOWN: if aligned_q=1 -> UP, glitch_count++, no up_event. Else if q_cnt==DOWN_CYCLES-1 -> DOWN with down_event=1 and drop_count++. Else q_cnt++.
- eth_up = 1 in UP and QUAL_DOWN; 0 in DOWN and QUAL_UP. Registered, so glitches shorter than DOWN_CYCLES never reach eth_up.
- Latency: let N be the first edge at which aligned_q becomes 1 from DOWN. eth_up rises at edge N+UP_CYCLES. Falling follows the same rule with DOWN_CYCLES.
- Counters saturate at all-ones and do not wrap.
- clear_counts coinciding with an increment: the counter takes value 1; the event is not lost.
- Reset values: state=DOWN, q_cnt=0, aligned_q=0, eth_up=0, up_event=0, down_event=0, drop_count=0, glitch_count=0.
- Reset mid-operation returns to DOWN on the next edge with no event pulses. Counters are cleared.
- up_event and down_event are never high in the same cycle, and each is high for exactly one cycle per transition.

Optional Feature:
- Macro: ETH_LINK_UPTIME_EN.
- Defined:
  - Adds output uptime (32 bits): counts cycles while eth_up=1.
  - Zeroed on the cycle up_event fires and on reset.
  - Holds its value while eth_up=0 so the last session length stays readable.
  - Saturates at 32'hFFFF_FFFF.
  - Not affected by clear_counts.
- Undefined: no uptime port or logic. All other behaviour is identical.

Decomposition:
- Shared package eth_pkg:
  - FSM state encoding: DOWN=0, QUAL_UP=1, UP=2, QUAL_DOWN=3.
  - Default UP_CYCLES/DOWN_CYCLES constants.
  - Saturating-increment function.
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, clr, count), instantiated for drop_count, glitch_count and, when enabled, uptime.
- The FSM stays in the top module.

Test Plan (UP_CYCLES=8, DOWN_CYCLES=4, CNT_W=4):
- Reset, then rx_aligned=1 held -> eth_up=0 for 8 edges after aligned_q rises; eth_up=1 at edge N+8; single up_event on that edge.
- From UP, rx_aligned=0 for 2 cycles then 1 -> eth_up stays 1 throughout; glitch_count=1; no down_event; drop_count=0.
- From UP, rx_aligned=0 held -> eth_up falls at edge N+4; one down_event; drop_count=1.
- In QUAL_UP, rx_aligned=1 for 5 cycles then 0 -> returns to DOWN; eth_up never rises; no counts change.
- Force 17 drops -> drop_count saturates at 4'hF. Then clear_counts coincident with an 18th drop -> drop_count=1.
- Reset asserted for 1 cycle while in QUAL_DOWN -> next edge: state DOWN, eth_up=0, counts=0, no event pulses. With ETH_LINK_UPTIME_EN, uptime=0.
